// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment scanner with per-frame data latch,
// leading-zero blanking, frame-done strobe, enable gate and output polarity.
module seg_scan #(
  parameter int DIGITS         = 8,
  parameter int DIV            = 50000,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            segment,
  output logic                  frame_done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic                shadow_blz;

  logic                tick;
  logic                frame_start;
  logic [IDX_W-1:0]    next_idx;
  logic [IDX_W-1:0]    nib;
  logic [4*DIGITS-1:0] src_data;
  logic [DIGITS-1:0]   src_dp;
  logic                src_blz;
  logic [3:0]          nibble;
  logic                nib_dp;
  logic                upper_nz;
  logic                blank;
  logic [6:0]          pat;
  logic [DIGITS-1:0]   sel_next;
  logic [7:0]          seg_next;

  // Next-slot decode; at a frame start the pattern comes from the live inputs
  // being captured so slot 0 already reflects the new frame.
  always_comb begin
    tick        = (div_cnt == DIV_W'(DIV - 1));
    next_idx    = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    frame_start = tick && (next_idx == '0);
    src_data    = frame_start ? data     : shadow_data;
    src_dp      = frame_start ? dp       : shadow_dp;
    src_blz     = frame_start ? blank_lz : shadow_blz;
    nib         = IDX_W'(DIGITS - 1) - next_idx;

    nibble   = '0;
    nib_dp   = 1'b0;
    upper_nz = 1'b0;
    sel_next = '0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (IDX_W'(j) == nib) begin
        nibble = src_data[4*j +: 4];
        nib_dp = src_dp[j];
      end
      if (IDX_W'(j) >= nib && src_data[4*j +: 4] != 4'h0) upper_nz = 1'b1;
      sel_next[j] = (IDX_W'(j) == next_idx);
    end
    blank = src_blz && (nib != '0) && !upper_nz;

    case (nibble)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase

    seg_next = {nib_dp, (blank ? 7'h00 : pat)} ^ SEG_OFF;
    sel_next = sel_next ^ SEL_OFF;
  end

  // Prescaler, slot counter, frame latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= IDX_W'(DIGITS - 1);
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_blz  <= 1'b0;
      sel         <= SEL_OFF;
      segment     <= SEG_OFF;
      frame_done  <= 1'b0;
    end else if (!enable) begin
      div_cnt    <= '0;
      idx        <= IDX_W'(DIGITS - 1);
      sel        <= SEL_OFF;
      segment    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_start;
      if (tick) begin
        div_cnt <= '0;
        idx     <= next_idx;
        sel     <= sel_next;
        segment <= seg_next;
        if (frame_start) begin
          shadow_data <= data;
          shadow_dp   <= dp;
          shadow_blz  <= blank_lz;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: main instance (8 digits, DIV=4, default
// polarity) and a polarity instance (4 digits, DIV=1, inverted polarity).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  sel;
  logic [7:0]  segment;
  logic        frame_done;

  logic        p_rst_n = 1'b0;
  logic        p_enable = 1'b0;
  logic [15:0] p_data = '0;
  logic [3:0]  p_dp = '0;
  logic        p_blank_lz = 1'b0;
  logic [3:0]  p_sel;
  logic [7:0]  p_segment;
  logic        p_frame_done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] sel_tbl   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] basic_tbl [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
  logic [7:0] lz_tbl    [8] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h3F, 8'h3F};
  logic [3:0] psel_tbl  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [7:0] pseg_tbl  [4] = '{8'h80, 8'h99, 8'hA4, 8'hF9};

  logic [7:0] esel;
  logic [7:0] eseg;
  logic       efd;
  int unsigned k;

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(8), .DIV(4), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data), .dp(dp),
    .blank_lz(blank_lz), .sel(sel), .segment(segment), .frame_done(frame_done)
  );

  seg_scan #(.DIGITS(4), .DIV(1), .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) u_pol (
    .clk(clk), .rst_n(p_rst_n), .enable(p_enable), .data(p_data), .dp(p_dp),
    .blank_lz(p_blank_lz), .sel(p_sel), .segment(p_segment), .frame_done(p_frame_done)
  );

  task automatic test_reset;
    rst_n = 1'b0; p_rst_n = 1'b0; enable = 1'b1; p_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({sel, segment, frame_done} !== {8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got sel=%h seg=%h fd=%b, want sel=ff seg=00 fd=0", sel, segment, frame_done);
    end
    vectors++;
    if ({p_sel, p_segment, p_frame_done} !== {4'h0, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_pol: got sel=%h seg=%h fd=%b, want sel=0 seg=ff fd=0", p_sel, p_segment, p_frame_done);
    end
  endtask

  task automatic test_polarity;
    p_data = 16'h8421; p_dp = '0; p_blank_lz = 1'b0;
    @(negedge clk);
    p_rst_n = 1'b1;
    for (int unsigned e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      vectors++;
      if ({p_sel, p_segment, p_frame_done} !== {psel_tbl[(e-1)%4], pseg_tbl[(e-1)%4], (e % 4 == 1)}) begin
        miscompares++;
        $display("FAIL polarity e=%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b", e,
                 p_sel, p_segment, p_frame_done, psel_tbl[(e-1)%4], pseg_tbl[(e-1)%4], (e % 4 == 1));
      end
    end
  endtask

  task automatic test_basic_scan;
    data = 32'h0123_4567; dp = '0; blank_lz = 1'b0; enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned e = 1; e <= 36; e++) begin
      @(posedge clk); #1;
      if (e < 4) begin
        esel = 8'hFF; eseg = 8'h00; efd = 1'b0;
      end else begin
        k = ((e - 4) / 4) % 8;
        esel = sel_tbl[k]; eseg = basic_tbl[k]; efd = ((e - 4) % 32 == 0);
      end
      vectors++;
      if ({sel, segment, frame_done} !== {esel, eseg, efd}) begin
        miscompares++;
        $display("FAIL basic e=%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 e, sel, segment, frame_done, esel, eseg, efd);
      end
    end
  endtask

  // Continues from edge 36 of test_basic_scan.
  task automatic test_no_tearing;
    for (int unsigned e = 37; e <= 100; e++) begin
      @(posedge clk); #1;
      k = ((e - 4) / 4) % 8;
      esel = sel_tbl[k];
      eseg = (e < 68) ? basic_tbl[k] : 8'h71;
      efd  = ((e - 4) % 32 == 0);
      vectors++;
      if ({sel, segment, frame_done} !== {esel, eseg, efd}) begin
        miscompares++;
        $display("FAIL tearing e=%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 e, sel, segment, frame_done, esel, eseg, efd);
      end
      if (e == 50) data = 32'hFFFF_FFFF;
    end
  endtask

  // Continues from edge 100; new inputs take effect at frame start edge 132.
  task automatic test_lz_blank;
    data = 32'h0000_0A00; dp = 8'h80; blank_lz = 1'b1;
    for (int unsigned e = 101; e <= 195; e++) begin
      @(posedge clk); #1;
      k = ((e - 4) / 4) % 8;
      esel = sel_tbl[k];
      if (e < 132)      eseg = 8'h71;
      else if (e < 164) eseg = lz_tbl[k];
      else              eseg = (k == 7) ? 8'h3F : 8'h00;
      efd = ((e - 4) % 32 == 0);
      vectors++;
      if ({sel, segment, frame_done} !== {esel, eseg, efd}) begin
        miscompares++;
        $display("FAIL lz_blank e=%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 e, sel, segment, frame_done, esel, eseg, efd);
      end
      if (e == 150) begin
        data = '0; dp = '0;
      end
    end
  endtask

  task automatic test_enable_reset;
    rst_n = 1'b0;
    #1;
    data = 32'h0123_4567; dp = '0; blank_lz = 1'b0; enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned e = 1; e <= 28; e++) begin
      @(posedge clk); #1;
      if (e < 4 || e >= 26) begin
        esel = 8'hFF; eseg = 8'h00; efd = 1'b0;
      end else begin
        k = ((e - 4) / 4) % 8;
        esel = sel_tbl[k]; eseg = basic_tbl[k]; efd = ((e - 4) % 32 == 0);
      end
      vectors++;
      if ({sel, segment, frame_done} !== {esel, eseg, efd}) begin
        miscompares++;
        $display("FAIL enable_drop e=%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 e, sel, segment, frame_done, esel, eseg, efd);
      end
      if (e == 25) enable = 1'b0;
    end
    enable = 1'b1;
    for (int unsigned f = 1; f <= 6; f++) begin
      @(posedge clk); #1;
      if (f < 4) begin
        esel = 8'hFF; eseg = 8'h00; efd = 1'b0;
      end else begin
        esel = 8'hFE; eseg = 8'h3F; efd = (f == 4);
      end
      vectors++;
      if ({sel, segment, frame_done} !== {esel, eseg, efd}) begin
        miscompares++;
        $display("FAIL reenable f=%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 f, sel, segment, frame_done, esel, eseg, efd);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({sel, segment, frame_done} !== {8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got sel=%h seg=%h fd=%b, want sel=ff seg=00 fd=0", sel, segment, frame_done);
    end
  endtask

  initial begin
    test_reset;
    test_polarity;
    test_basic_scan;
    test_no_tearing;
    test_lz_blank;
    test_enable_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
